// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte slave: oversamples sclk/cs_n/mosi in the clk domain, deframes
// MOSI into bytes (one-cycle rx_valid pulses) and shifts tx_byte out on miso MSB first.
module spi_byte_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [BYTE_WIDTH-1:0] tx_byte,
    output logic                  rx_valid,
    output logic [BYTE_WIDTH-1:0] rx_byte,
    output logic                  busy
);

    localparam int CNT_W = $clog2(BYTE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BYTE_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [BYTE_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [BYTE_WIDTH-1:0]  rx_byte_q, rx_byte_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   miso_q, miso_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_comb begin
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_prev_q;
        sclk_fall = ~sclk_s & sclk_prev_q;
        // The cs_n chain resets high; only trust a falling edge once a real
        // high has been seen after reset, so a frame in progress is not re-entered.
        cs_fall   = armed_q & cs_prev_q & ~cs_s;
        cs_rise   = cs_s & ~cs_prev_q;

        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_byte;
                    busy_d     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[BYTE_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_byte_d  = {rx_shift_q[BYTE_WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    // bit_cnt==0 on a falling edge means a byte just completed.
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[BYTE_WIDTH-2:0], 1'b0};
                    end else begin
                        tx_shift_d = tx_byte;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        miso_d = (state_d == ACTIVE) ? tx_shift_d[BYTE_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave: a bit-banged SPI master at clk = 8x sclk,
// with received bytes collected by a negedge monitor and checked in sequence.
module tb_spi_byte_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_byte = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int long_pulses = 0;
    logic rv_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] rd;

    spi_byte_slave #(.SYNC_STAGES(2), .BYTE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_byte(tx_byte), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every rx_valid pulse and flag any pulse wider than one clk.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_byte);
            if (rv_prev) long_pulses++;
        end
        rv_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits of tx (from bit 7 down) as master; returns bits read on miso.
    task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = tx[7-i];
            wait_clks(4);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            wait_clks(4);
        end
    endtask

    task automatic frame_end();
        sclk = 1'b0;
        wait_clks(4);
        cs_n = 1'b1;
        wait_clks(8);
    endtask

    initial begin
        // Reset state
        wait_clks(3);
        check("reset_miso", miso, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_byte", rx_byte, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        wait_clks(6);
        check("idle_busy", busy, 0);

        // Frame 0x01, 0xAB with tx 0xC3 then 0x5A
        got_q.delete();
        tx_byte = 8'hC3;
        cs_n = 1'b0;
        wait_clks(8);
        check("frame_busy", busy, 1);
        spi_bits(8, 8'h01, rd);
        check("miso_byte0", rd, 8'hC3);
        tx_byte = 8'h5A;
        spi_bits(8, 8'hAB, rd);
        check("miso_byte1", rd, 8'h5A);
        frame_end();
        check("post_frame_busy", busy, 0);
        check("post_frame_miso", miso, 0);
        check("frame_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("frame_byte0", got_q[0], 8'h01);
            check("frame_byte1", got_q[1], 8'hAB);
        end
        check("pulse_width", long_pulses, 0);

        // Partial byte discarded, next frame 0x02
        got_q.delete();
        cs_n = 1'b0;
        wait_clks(8);
        spi_bits(5, 8'hFF, rd);
        frame_end();
        check("partial_count", got_q.size(), 0);
        check("partial_rx_byte_kept", rx_byte, 8'hAB);
        cs_n = 1'b0;
        wait_clks(8);
        spi_bits(8, 8'h02, rd);
        frame_end();
        check("after_partial_count", got_q.size(), 1);
        if (got_q.size() == 1) check("after_partial_byte", got_q[0], 8'h02);

        // Reset mid-frame; frame in progress must not be re-entered
        got_q.delete();
        cs_n = 1'b0;
        wait_clks(8);
        spi_bits(3, 8'hE0, rd);
        #1 rst_n = 1'b0;
        wait_clks(2);
        check("midrst_miso", miso, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_byte", rx_byte, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        wait_clks(6);
        spi_bits(8, 8'hFF, rd);
        check("stale_frame_busy", busy, 0);
        check("stale_frame_count", got_q.size(), 0);
        frame_end();
        cs_n = 1'b0;
        wait_clks(8);
        spi_bits(8, 8'h04, rd);
        frame_end();
        check("after_rst_count", got_q.size(), 1);
        if (got_q.size() == 1) check("after_rst_byte", got_q[0], 8'h04);
        check("after_rst_rx_byte", rx_byte, 8'h04);

        // Continuous 16-byte frame
        got_q.delete();
        tx_byte = 8'h96;
        cs_n = 1'b0;
        wait_clks(8);
        for (int b = 0; b < 16; b++) begin
            spi_bits(8, b[7:0], rd);
            check("burst_miso", rd, 8'h96);
        end
        frame_end();
        check("burst_count", got_q.size(), 16);
        for (int b = 0; b < 16; b++) begin
            if (b < got_q.size()) check("burst_byte", got_q[b], b);
        end
        check("burst_pulse_width", long_pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
